// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared state encoding and default width for calculator operation controllers
package calc_pkg;

   localparam int CALC_WIDTH = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } calc_state_t;

endpackage

// File: rtl/mult_shift_add_dp.sv
// rtl/mult_shift_add_dp.sv - shift-and-add multiply datapath driven by load/step strobes
module mult_shift_add_dp
   import calc_pkg::*;
#(
   parameter int WIDTH = CALC_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load,
   input  logic                 step,
   input  logic [WIDTH-1:0]     multiplicand,
   input  logic [WIDTH-1:0]     multiplier,
   output logic [2*WIDTH-1:0]   acc_step
);

   logic [WIDTH-1:0]   a_reg;
   logic [WIDTH-1:0]   b_reg;
   logic [2*WIDTH-1:0] acc;
   logic [WIDTH:0]     sum;

   // One iteration: conditional add into the upper half, carry kept as the
   // top bit of sum, then the whole {carry, upper, lower} shifts right by one.
   // acc_step is the value the accumulator takes on a step edge, so the
   // controller can capture the final product on that same edge.
   always_comb begin
      sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (b_reg[0] ? {1'b0, a_reg} : '0);
      acc_step = (2*WIDTH)'({sum, acc[WIDTH-1:0]} >> 1);
   end

   // Operand latch on load, add-shift iteration on step.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_reg <= '0;
         b_reg <= '0;
         acc   <= '0;
      end else if (load) begin
         a_reg <= multiplicand;
         b_reg <= multiplier;
         acc   <= '0;
      end else if (step) begin
         acc   <= acc_step;
         b_reg <= b_reg >> 1;
      end
   end

endmodule

// File: rtl/mult_seq_ctrl.sv
// rtl/mult_seq_ctrl.sv - sequential multiply controller: FSM, bit counter and product register
module mult_seq_ctrl
   import calc_pkg::*;
#(
   parameter int WIDTH = CALC_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [WIDTH-1:0]     multiplicand,
   input  logic [WIDTH-1:0]     multiplier,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   calc_state_t        state;
   calc_state_t        state_nxt;
   logic [CW-1:0]      cnt;
   logic               load;
   logic               step;
   logic               zero_op;
   logic [2*WIDTH-1:0] acc_step;

   assign zero_op = (multiplicand == '0) || (multiplier == '0);

   mult_shift_add_dp #(.WIDTH(WIDTH)) u_dp (
      .clk          (clk),
      .rst          (rst),
      .load         (load),
      .step         (step),
      .multiplicand (multiplicand),
      .multiplier   (multiplier),
      .acc_step     (acc_step)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state and datapath strobes; a zero operand skips RUN entirely.
   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      step      = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               load      = 1'b1;
               state_nxt = zero_op ? DONE : RUN;
            end
         end
         RUN: begin
            step = 1'b1;
            if (cnt == LAST) state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Iteration counter; the edge with cnt at LAST performs the final step.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)       cnt <= '0;
      else if (load) cnt <= '0;
      else if (step) cnt <= cnt + 1'b1;
   end

   // Product changes only on DONE entry: final step result, or zero on early exit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                               product <= '0;
      else if (step && cnt == LAST)          product <= acc_step;
      else if (load && zero_op)              product <= '0;
   end

   assign busy = (state != IDLE);
   assign done = (state == DONE);

endmodule
